// File: rtl/sbox_gf4_front.sv
// sbox_gf4_front: AES S-box front stage (inverse affine, GF(2^8)->GF((2^4)^2) map, delta), 2-stage valid/ready; SBOX_FRONT_CNT_EN adds cnt_o transfer counter
module sbox_gf4_front #(
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [7:0]       data_i,
  input  logic             mode_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [3:0]       ah_o,
  output logic [3:0]       al_o,
  output logic [3:0]       delta_o,
  output logic             mode_o,
`ifdef SBOX_FRONT_CNT_EN
  output logic [15:0]      cnt_o,
`endif
  output logic [TAG_W-1:0] tag_o
);
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      p = p ^ (b[i] ? t : 4'h0);
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction
  function automatic logic [7:0] invaff(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction
  logic             s1_valid, s2_valid, adv1, adv2, s1_mode, a_a, a_b, a_c;
  logic [3:0]       s1_ah, s1_al, delta;
  logic [7:0]       b, q;
  logic [TAG_W-1:0] s1_tag;
  assign adv2    = ~s2_valid | ready_i;
  assign adv1    = ~s1_valid | adv2;
  assign ready_o = adv1 & ~flush_i;
  assign valid_o = s2_valid;
  always_comb begin
    b     = mode_i ? invaff(data_i) : data_i;
    a_a   = b[1] ^ b[7];
    a_b   = b[5] ^ b[7];
    a_c   = b[4] ^ b[6];
    q     = {a_b, a_b ^ b[2] ^ b[3], a_a ^ a_c, a_c ^ b[5], b[2] ^ b[4], a_a, b[1] ^ b[2], a_c ^ b[0] ^ b[5]};
    delta = gmul(4'hC, gmul(s1_ah, s1_ah)) ^ gmul(s1_ah, s1_al) ^ gmul(s1_al, s1_al);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_ah    <= '0;
      s1_al    <= '0;
      s1_mode  <= 1'b0;
      s1_tag   <= '0;
      ah_o     <= '0;
      al_o     <= '0;
      delta_o  <= '0;
      mode_o   <= 1'b0;
      tag_o    <= '0;
    end else begin
      s2_valid <= flush_i ? 1'b0 : adv2 ? s1_valid : s2_valid;
      s1_valid <= flush_i ? 1'b0 : adv1 ? valid_i : s1_valid;
      if (adv2) begin
        ah_o    <= s1_ah;
        al_o    <= s1_al;
        delta_o <= delta;
        mode_o  <= s1_mode;
        tag_o   <= s1_tag;
      end
      if (adv1) begin
        s1_ah   <= q[7:4];
        s1_al   <= q[3:0];
        s1_mode <= mode_i;
        s1_tag  <= tag_i;
      end
    end
  end
`ifdef SBOX_FRONT_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_o <= '0;
    else if (valid_o && ready_i) cnt_o <= cnt_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_sbox_gf4_front.sv
// tb_sbox_gf4_front: scoreboard bench for sbox_gf4_front (directed vectors, full byte sweep, back-pressure, flush, reset, optional counter)
module tb_sbox_gf4_front;
  logic        clk = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_o, mode_i, valid_o, ready_i, mode_o;
  logic [7:0]  data_i;
  logic [3:0]  tag_i, ah_o, al_o, delta_o, tag_o;
`ifdef SBOX_FRONT_CNT_EN
  logic [15:0] cnt_o;
`endif
  int          total = 0;
  int          bad = 0;
  logic [16:0] sb [$];
  localparam logic [7:0] COLS [8] = '{8'h01, 8'h26, 8'h4A, 8'h40, 8'h39, 8'hD1, 8'h31, 8'hE4};
  always #5 clk = ~clk;
  sbox_gf4_front #(.TAG_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .mode_i(mode_i), .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i),
    .ah_o(ah_o), .al_o(al_o), .delta_o(delta_o), .mode_o(mode_o),
`ifdef SBOX_FRONT_CNT_EN
    .cnt_o(cnt_o),
`endif
    .tag_o(tag_o)
  );
  function automatic logic [3:0] fmul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (7'(a) << i);
    return p[3:0] ^ (p[4] ? 4'h3 : 4'h0) ^ (p[5] ? 4'h6 : 4'h0) ^ (p[6] ? 4'hC : 4'h0);
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction
  function automatic logic [11:0] model(input logic m, input logic [7:0] d);
    logic [7:0] b;
    logic [7:0] q;
    b = m ? (rl(d, 1) ^ rl(d, 3) ^ rl(d, 6) ^ 8'h05) : d;
    q = '0;
    for (int i = 0; i < 8; i++) if (b[i]) q = q ^ COLS[i];
    return {q[7:4], q[3:0], fmul(4'hC, fmul(q[7:4], q[7:4])) ^ fmul(q[7:4], q[3:0]) ^ fmul(q[3:0], q[3:0])};
  endfunction
  task automatic chk(input string n, input logic [16:0] act, input logic [16:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic send(input logic m, input logic [7:0] d, input logic [3:0] t, input logic [11:0] e);
    valid_i = 1'b1;
    mode_i  = m;
    data_i  = d;
    tag_i   = t;
    for (int w = 0; ; w++) begin
      @(negedge clk);
      if (ready_o) begin
        sb.push_back({e, m, t});
        break;
      end
      if (w == 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout data=%h tag=%h", d, t);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask
  task automatic drain();
    for (int w = 0; w < 200 && sb.size() != 0; w++) begin
      @(posedge clk); #1;
    end
    chk("drain_left", 17'(sb.size()), 17'd0);
  endtask
  always @(negedge clk) begin
    if (!rst_i && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stale_out actual=%h required=none", {ah_o, al_o, delta_o, mode_o, tag_o});
      end else chk("out", {ah_o, al_o, delta_o, mode_o, tag_o}, sb.pop_front());
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    mode_i = 1'b0; data_i = '0; tag_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", 17'(valid_o), 17'd0);
    chk("rst_data", {ah_o, al_o, delta_o, mode_o, tag_o}, 17'd0);
    chk("rst_ready", 17'(ready_o), 17'd1);
`ifdef SBOX_FRONT_CNT_EN
    chk("rst_cnt", 17'(cnt_o), 17'd0);
`endif
    @(posedge clk); #1;
    send(1'b0, 8'h00, 4'h0, 12'h000);
    send(1'b0, 8'h01, 4'h1, 12'h011);
    send(1'b1, 8'h7C, 4'h2, 12'h011);
    send(1'b1, 8'h63, 4'h3, 12'h000);
    send(1'b0, 8'h02, 4'h4, 12'h26E);
    send(1'b0, 8'h04, 4'h5, 12'h4A1);
    send(1'b0, 8'h80, 4'h6, 12'hE43);
    drain();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 256; i++) send(m[0], 8'(i), 4'(i), model(m[0], 8'(i)));
    drain();
    ready_i = 1'b0;
    send(1'b0, 8'h02, 4'h1, 12'h26E);
    send(1'b0, 8'h04, 4'h2, 12'h4A1);
    valid_i = 1'b1; mode_i = 1'b0; data_i = 8'h80; tag_i = 4'h3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_ready", 17'(ready_o), 17'd0);
      chk("bp_valid", 17'(valid_o), 17'd1);
      chk("bp_hold", {ah_o, al_o, delta_o, mode_o, tag_o}, {12'h26E, 1'b0, 4'h1});
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp_accept", 17'(ready_o), 17'd1);
    if (ready_o) sb.push_back({12'hE43, 1'b0, 4'h3});
    @(posedge clk); #1;
    valid_i = 1'b0;
    drain();
    ready_i = 1'b0;
    send(1'b0, 8'h01, 4'h4, 12'h011);
    send(1'b0, 8'h00, 4'h5, 12'h000);
    flush_i = 1'b1; valid_i = 1'b1; data_i = 8'h04; tag_i = 4'h6;
    @(negedge clk);
    chk("flush_ready", 17'(ready_o), 17'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    sb.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("flush_valid", 17'(valid_o), 17'd0);
      @(posedge clk); #1;
    end
    ready_i = 1'b0;
    send(1'b0, 8'h80, 4'h7, 12'hE43);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0; ready_i = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rst2_valid", 17'(valid_o), 17'd0);
    chk("rst2_data", {ah_o, al_o, delta_o, mode_o, tag_o}, 17'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst2_idle", 17'(valid_o), 17'd0);
    @(posedge clk); #1;
    send(1'b1, 8'h7C, 4'h8, 12'h011);
    drain();
`ifdef SBOX_FRONT_CNT_EN
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("cnt_rst", 17'(cnt_o), 17'd0);
    @(posedge clk); #1;
    valid_i = 1'b1; mode_i = 1'b0; data_i = 8'h01; tag_i = 4'h9;
    for (int acc = 0; acc < 32'h10002; ) begin
      @(negedge clk);
      if (ready_o) begin
        sb.push_back({12'h011, 1'b0, 4'h9});
        acc++;
      end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    drain();
    @(negedge clk);
    chk("cnt_wrap", 17'(cnt_o), 17'd2);
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("cnt_flush", 17'(cnt_o), 17'd2);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("cnt_rst2", 17'(cnt_o), 17'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
